// File: rtl/cond_fork_n_buf_if.sv
// Bundle of the producer-side and consumer-side handshakes of cond_fork_n_buf.
// A token moves on a clock edge where its driver asserts i_drive (or the FIFO holds
// o_driveNext[k]) and the receiver asserts o_free (or i_freeNext[k]). A driver holds
// the token and its select mask stable until the token is taken.
interface cond_fork_n_buf_if #(
    parameter int N     = 2,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic               i_drive;
    logic               o_free;
    logic [WIDTH-1:0]   i_data;
    logic [N-1:0]       i_valid;
    logic [N-1:0]       o_driveNext;
    logic [N-1:0]       i_freeNext;
    logic [N*WIDTH-1:0] o_data;
    logic [CNT_W-1:0]   o_drop_cnt;

    modport slave (
        input  i_drive, i_data, i_valid, i_freeNext,
        output o_free, o_driveNext, o_data, o_drop_cnt
    );

    modport master (
        output i_drive, i_data, i_valid, i_freeNext,
        input  o_free, o_driveNext, o_data, o_drop_cnt
    );
endinterface

// File: rtl/cond_fork_n_buf.sv
// N-way conditional fork: each accepted token is copied into the FIFO of every
// selected branch (or only the lowest one), and tokens with no selected branch are counted as drops.
module cond_fork_n_buf #(
    parameter int N        = 2,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int SEL_MODE = 0,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rstn,
    cond_fork_n_buf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [N-1:0]     SEL_ONE  = N'(1);
    localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

    logic [N-1:0]       sel;
    logic [N-1:0]       full;
    logic [N-1:0]       empty;
    logic [N-1:0]       push;
    logic [N-1:0]       pop;
    logic               free;
    logic               drop;
    logic [CNT_W-1:0]   drop_cnt;
    logic [N*WIDTH-1:0] data_out;

    // In FIRST mode, v & -v isolates the lowest set bit of the mask.
    always_comb begin
        sel = bus.i_valid;
        if (SEL_MODE == 1) begin
            sel = bus.i_valid & (~bus.i_valid + SEL_ONE);
        end
    end

    // Acceptance looks only at registered counts, so a full branch blocks even while it pops.
    assign free = rstn & bus.i_drive & (&(~sel | ~full));
    assign push = {N{free}} & sel;
    assign drop = free & ~(|sel);
    assign pop  = ~empty & bus.i_freeNext;

    for (genvar k = 0; k < N; k++) begin : g_branch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W:0]   count;

        assign full[k]  = (count == CNT_FULL);
        assign empty[k] = (count == '0);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[k]) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop[k])  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push[k], pop[k]})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end

        // Storage needs no reset: a slot is only read after it has been written.
        always_ff @(posedge clk) begin
            if (push[k]) mem[wr_ptr] <= bus.i_data;
        end

        assign data_out[k*WIDTH +: WIDTH] = empty[k] ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_ONE;
        end
    end

    assign bus.o_free      = free;
    assign bus.o_driveNext = ~empty;
    assign bus.o_data      = data_out;
    assign bus.o_drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_cond_fork_n_buf.sv
// Bench for cond_fork_n_buf: a MULTICAST instance and a FIRST-mode instance with a 2-bit
// drop counter, checked against per-branch expected queues.
`timescale 1ns/1ps
module tb_cond_fork_n_buf;
    localparam int N     = 2;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cond_fork_n_buf_if #(.N(N), .WIDTH(W), .CNT_W(16)) if_m ();
    cond_fork_n_buf_if #(.N(N), .WIDTH(W), .CNT_W(2))  if_f ();

    cond_fork_n_buf #(.N(N), .WIDTH(W), .DEPTH(DEPTH), .SEL_MODE(0), .CNT_W(16)) dut_m (
        .clk(clk), .rstn(rstn), .bus(if_m.slave)
    );
    cond_fork_n_buf #(.N(N), .WIDTH(W), .DEPTH(DEPTH), .SEL_MODE(1), .CNT_W(2)) dut_f (
        .clk(clk), .rstn(rstn), .bus(if_f.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q   [N][$];
    logic [W-1:0] exp_f_q [N][$];
    int drop_m = 0;
    int drop_f = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] first_bit(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitors ----------------
    task automatic mon_m();
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = (exp_q[k].size() != 0);
        check("m_drive_next", 64'(if_m.o_driveNext), 64'(e));
        for (int k = 0; k < N; k++) begin
            if (if_m.o_driveNext[k] && if_m.i_freeNext[k] && exp_q[k].size() != 0)
                check($sformatf("m_data%0d", k), 64'(if_m.o_data[k*W +: W]), 64'(exp_q[k].pop_front()));
        end
    endtask

    task automatic mon_f();
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = (exp_f_q[k].size() != 0);
        check("f_drive_next", 64'(if_f.o_driveNext), 64'(e));
        for (int k = 0; k < N; k++) begin
            if (if_f.o_driveNext[k] && if_f.i_freeNext[k] && exp_f_q[k].size() != 0)
                check($sformatf("f_data%0d", k), 64'(if_f.o_data[k*W +: W]), 64'(exp_f_q[k].pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            mon_m();
            mon_f();
        end
    end

    // Producer must hold a blocked token unchanged.
    logic         m_blk = 1'b0;
    logic         f_blk = 1'b0;
    logic [W-1:0] m_pd, f_pd;
    logic [N-1:0] m_pv, f_pv;
    always @(posedge clk) begin
        if (rstn && m_blk)
            assert (if_m.i_drive && if_m.i_data == m_pd && if_m.i_valid == m_pv)
                else $error("producer changed a blocked token on dut_m");
        if (rstn && f_blk)
            assert (if_f.i_drive && if_f.i_data == f_pd && if_f.i_valid == f_pv)
                else $error("producer changed a blocked token on dut_f");
        m_blk <= rstn & if_m.i_drive & ~if_m.o_free;
        f_blk <= rstn & if_f.i_drive & ~if_f.o_free;
        m_pd  <= if_m.i_data;
        m_pv  <= if_m.i_valid;
        f_pd  <= if_f.i_data;
        f_pv  <= if_f.i_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic send_m(input logic [W-1:0] d, input logic [N-1:0] v, output int waited);
        if_m.i_drive = 1'b1;
        if_m.i_data  = d;
        if_m.i_valid = v;
        waited = 0;
        @(negedge clk);
        while (!if_m.o_free && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        check("m_send_accept", 64'(if_m.o_free), 64'd1);
        @(posedge clk);
        for (int k = 0; k < N; k++) if (v[k]) exp_q[k].push_back(d);
        if (v == '0) drop_m++;
        #1 if_m.i_drive = 1'b0;
    endtask

    task automatic send_f(input logic [W-1:0] d, input logic [N-1:0] v, output int waited);
        logic [N-1:0] s;
        s = first_bit(v);
        if_f.i_drive = 1'b1;
        if_f.i_data  = d;
        if_f.i_valid = v;
        waited = 0;
        @(negedge clk);
        while (!if_f.o_free && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        check("f_send_accept", 64'(if_f.o_free), 64'd1);
        @(posedge clk);
        for (int k = 0; k < N; k++) if (s[k]) exp_f_q[k].push_back(d);
        if (s == '0 && drop_f < 3) drop_f++;
        #1 if_f.i_drive = 1'b0;
    endtask

    task automatic probe_m(input logic [N-1:0] v, input logic exp_free, input string tag);
        if_m.i_drive = 1'b1;
        if_m.i_valid = v;
        #1 check(tag, 64'(if_m.o_free), 64'(exp_free));
        if_m.i_drive = 1'b0;
    endtask

    task automatic drain_m();
        int n = 0;
        if_m.i_freeNext = '1;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 50) begin
            sync();
            n++;
        end
        if_m.i_freeNext = '0;
        check("m_drain", 64'(if_m.o_driveNext), 64'd0);
    endtask

    task automatic drain_f();
        int n = 0;
        if_f.i_freeNext = '1;
        while ((exp_f_q[0].size() != 0 || exp_f_q[1].size() != 0) && n < 50) begin
            sync();
            n++;
        end
        if_f.i_freeNext = '0;
        check("f_drain", 64'(if_f.o_driveNext), 64'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            exp_f_q[k].delete();
        end
        drop_m = 0;
        drop_f = 0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        sync();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  w;
        bit  done;
        if_m.i_drive = 1'b0; if_m.i_data = '0; if_m.i_valid = '0; if_m.i_freeNext = '0;
        if_f.i_drive = 1'b0; if_f.i_data = '0; if_f.i_valid = '0; if_f.i_freeNext = '0;
        do_reset();
        check("rst_m_drive_next", 64'(if_m.o_driveNext), 64'd0);
        check("rst_m_drop_cnt",   64'(if_m.o_drop_cnt),  64'd0);
        check("rst_f_drop_cnt",   64'(if_f.o_drop_cnt),  64'd0);

        // FIRST mode: only the lowest selected branch receives the token
        send_f(32'h1111_0001, 2'b11, w);
        check("f_first_drive", 64'(if_f.o_driveNext), 64'd1);
        check("f_first_data",  64'(if_f.o_data[W-1:0]), 64'h1111_0001);
        for (int i = 0; i < 3; i++) begin
            send_f($urandom, 2'b00, w);
            check("f_drop_immediate", 64'(w), 64'd0);
        end
        check("f_drop_cnt3", 64'(if_f.o_drop_cnt), 64'd3);
        drain_f();

        // Drop counter saturates at 3 with a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_f($urandom, 2'b00, w);
            check("f_drop_sat", 64'(if_f.o_drop_cnt), 64'(drop_f));
        end
        check("f_sat_hold", 64'(if_f.o_drop_cnt), 64'd3);

        // Reset mid-stream with three tokens buffered
        send_m($urandom, 2'b00, w);
        if_m.i_freeNext = '0;
        for (int i = 0; i < 3; i++) send_m(32'hB000_0000 + i, 2'b11, w);
        check("pre_rst_drive", 64'(if_m.o_driveNext), 64'd3);
        check("pre_rst_cnt",   64'(if_m.o_drop_cnt),  64'd1);
        #1;
        if_m.i_drive = 1'b1;
        if_m.i_valid = 2'b11;
        rstn = 1'b0;
        #1;
        check("rst_async_drive", 64'(if_m.o_driveNext), 64'd0);
        check("rst_async_free",  64'(if_m.o_free),      64'd0);
        check("rst_async_data",  64'(if_m.o_data),      64'd0);
        check("rst_async_cnt",   64'(if_m.o_drop_cnt),  64'd0);
        if_m.i_drive = 1'b0;
        do_reset();
        repeat (3) sync();
        check("rst_no_old", 64'(if_m.o_driveNext), 64'd0);

        // MULTICAST to both branches, then pop each once
        send_m(32'hA5A5_0001, 2'b11, w);
        check("mc_drive", 64'(if_m.o_driveNext), 64'd3);
        check("mc_data0", 64'(if_m.o_data[W-1:0]),   64'hA5A5_0001);
        check("mc_data1", 64'(if_m.o_data[2*W-1:W]), 64'hA5A5_0001);
        if_m.i_freeNext = 2'b11;
        sync();
        if_m.i_freeNext = 2'b00;
        check("mc_popped", 64'(if_m.o_driveNext), 64'd0);

        // Backpressure on branch 0; branch 1 keeps flowing
        for (int i = 0; i < DEPTH; i++) begin
            send_m(32'hC000_0000 + i, 2'b01, w);
            check("bp_fill", 64'(w), 64'd0);
        end
        probe_m(2'b01, 1'b0, "bp_full_blocks");
        send_m(32'hD000_0001, 2'b10, w);
        check("bp_other_flows", 64'(w), 64'd0);

        // Atomic block while branch 0 is full; a pop frees it one cycle later
        sync();
        if_m.i_drive = 1'b1;
        if_m.i_valid = 2'b11;
        if_m.i_data  = 32'hE000_0001;
        @(negedge clk);
        check("atomic_block", 64'(if_m.o_free), 64'd0);
        @(posedge clk);
        #1 if_m.i_freeNext = 2'b01;
        @(negedge clk);
        check("no_free_path", 64'(if_m.o_free), 64'd0);
        @(posedge clk);
        #1 if_m.i_freeNext = 2'b00;
        @(negedge clk);
        check("free_after_pop", 64'(if_m.o_free), 64'd1);
        @(posedge clk);
        exp_q[0].push_back(32'hE000_0001);
        exp_q[1].push_back(32'hE000_0001);
        #1 if_m.i_drive = 1'b0;
        drain_m();

        // Random soak on the MULTICAST instance
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) send_m($urandom, 2'($urandom_range(0, 3)), w);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    if_m.i_freeNext = 2'($urandom_range(0, 3));
                    sync();
                end
            end
        join
        drain_m();
        check("m_soak_drops", 64'(if_m.o_drop_cnt), 64'(drop_m));

        // Random soak on the FIRST-mode instance
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) send_f($urandom, 2'($urandom_range(0, 3)), w);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    if_f.i_freeNext = 2'($urandom_range(0, 3));
                    sync();
                end
            end
        join
        drain_f();
        check("f_soak_drops", 64'(if_f.o_drop_cnt), 64'(drop_f));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
